// File: rtl/dac_interp_pkg.sv
// Shared DAC definitions: interpolator state encoding and counter widths.
package dac_interp_pkg;

    // The interpolator sits in IDLE until its first sample is loaded, then runs forever.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // The underrun counter saturates at the top of this width.
    localparam int UNDERRUN_W = 16;

endpackage : dac_interp_pkg

// File: rtl/dac_interp_ramp.sv
// Linear-interpolation datapath.
// At every segment boundary it latches a new slope.
// Between boundaries it accumulates that slope.
// The accumulator carries OSR fractional bits.
module dac_interp_ramp
    import dac_interp_pkg::*;
#(
    parameter int DATA_BW = 16,
    parameter int OSR     = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_evt,
    input  logic                      hold_full,
    input  logic signed [DATA_BW-1:0] hold_data,
    output logic signed [DATA_BW-1:0] dout
);

    localparam int ACC_W = DATA_BW + OSR + 1;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_BW:0]   step_q, step_d;
    logic [DATA_BW-1:0] cur_q, cur_d;
    logic [DATA_BW-1:0] dout_q, dout_d;
    logic [ACC_W-1:0]   cur_scaled;
    logic [ACC_W-1:0]   step_ext;
    logic [DATA_BW-1:0] hold_bits;

    // Next-state logic.
    // A boundary re-anchors the accumulator at the current endpoint.
    // If a sample is waiting, the slope toward it is latched as well.
    // At all other times the slope is added once per clock.
    always_comb begin
        hold_bits  = hold_data;
        cur_scaled = {cur_q[DATA_BW-1], cur_q, {OSR{1'b0}}};
        step_ext   = {{OSR{step_q[DATA_BW]}}, step_q};
        acc_d      = acc_q + step_ext;
        step_d     = step_q;
        cur_d      = cur_q;
        if (load_evt) begin
            acc_d = cur_scaled;
            if (hold_full) begin
                step_d = {hold_bits[DATA_BW-1], hold_bits} - {cur_q[DATA_BW-1], cur_q};
                cur_d  = hold_bits;
            end else begin
                step_d = '0;
            end
        end
        dout_d = acc_q[DATA_BW+OSR-1:OSR];
    end

    // Datapath registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            step_q <= '0;
            cur_q  <= '0;
            dout_q <= '0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
            cur_q  <= cur_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule : dac_interp_ramp

// File: rtl/dac_interp.sv
// Upsampling front end for the sigma-delta modulator.
// It accepts one sample per 2**OSR clocks and emits a linearly interpolated value every clock.
module dac_interp
    import dac_interp_pkg::*;
#(
    parameter int DATA_BW = 16,
    parameter int OSR     = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DATA_BW-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic signed [DATA_BW-1:0] dout,
    output logic                      running,
    output logic [UNDERRUN_W-1:0]     underrun_cnt
);

    logic [OSR-1:0]        phase_q, phase_d;
    logic [DATA_BW-1:0]    hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    state_e                state_q, state_d;
    logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
    logic                  load_evt;
    logic                  xfer;

    // The segment boundary is the last phase of each segment.
    // A full buffer may accept a new sample in the same cycle it is drained.
    always_comb begin
        load_evt = &phase_q;
        s_ready  = !hold_full_q | load_evt;
        xfer     = s_valid & s_ready;
    end

    // Next-state logic for:
    //  - the phase counter
    //  - the one-entry buffer
    //  - the run state
    //  - the saturating underrun counter
    always_comb begin
        phase_d     = phase_q + OSR'(1);
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        state_d     = state_q;
        underrun_d  = underrun_q;
        if (load_evt) begin
            hold_full_d = 1'b0;
        end
        if (xfer) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end
        if (load_evt && hold_full_q) begin
            state_d = RUN;
        end
        if (load_evt && !hold_full_q && (state_q == RUN) && (underrun_q != '1)) begin
            underrun_d = underrun_q + UNDERRUN_W'(1);
        end
    end

    // Control registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            state_q     <= IDLE;
            underrun_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            state_q     <= state_d;
            underrun_q  <= underrun_d;
        end
    end

    assign running      = (state_q == RUN);
    assign underrun_cnt = underrun_q;

    dac_interp_ramp #(
        .DATA_BW(DATA_BW),
        .OSR    (OSR)
    ) u_ramp (
        .clk      (clk),
        .rst      (rst),
        .load_evt (load_evt),
        .hold_full(hold_full_q),
        .hold_data(hold_q),
        .dout     (dout)
    );

endmodule : dac_interp

// File: tb/tb_dac_interp.sv
// Directed testbench for dac_interp (DATA_BW=16, OSR=6, 64 clocks per sample).
module tb_dac_interp;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] dout;
    logic               running;
    logic [15:0]        underrun_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dac_interp #(.DATA_BW(16), .OSR(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .dout        (dout),
        .running     (running),
        .underrun_cnt(underrun_cnt)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge; cyc numbers edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset for two edges; cyc = 0 is the sample right after the last reset edge (phase 0).
    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Offer one sample until it is accepted and check the edge on which the transfer happened.
    task automatic send(input logic signed [15:0] d, input int exp_cyc, input string tag);
        bit rdy;
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            rdy = s_ready;
            tick();
            n++;
        end while (!rdy && n < 200);
        s_valid = 1'b0;
        checks++;
        if (!rdy || cyc !== exp_cyc) begin
            errors++;
            $display("[TB] FAIL send_%s: accepted=%0b at cyc %0d, required accept at cyc %0d", tag, rdy, cyc, exp_cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dout !== 16'sd0 || s_ready !== 1'b1 || running !== 1'b0 || underrun_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: dout=%0d s_ready=%0b running=%0b underrun=%0d, required 0/1/0/0",
                     dout, s_ready, running, underrun_cnt);
        end
        for (int i = 0; i < 500; i++) begin
            tick();
            checks++;
            if (dout !== 16'sd0 || s_ready !== 1'b1 || running !== 1'b0 || underrun_cnt !== 16'd0) begin
                errors++;
                $display("[TB] FAIL idle_starved cyc %0d: dout=%0d s_ready=%0b running=%0b underrun=%0d, required 0/1/0/0",
                         cyc, dout, s_ready, running, underrun_cnt);
            end
        end
    endtask

    // Ramp 0 -> 6400 in steps of 100, then hold while starved.
    task automatic test_ramp();
        do_reset();
        send(16'sd0, 1, "zero");
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL running_early: running=%0b, required 0", running);
        end
        send(16'sd6400, 64, "6400");
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL running_set: running=%0b, required 1", running);
        end
        run_to(129);
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (int'(dout) !== 100 * k) begin
                errors++;
                $display("[TB] FAIL ramp_6400 k=%0d: dout=%0d, required %0d", k, dout, 100 * k);
            end
            tick();
        end
        checks++;
        if (dout !== 16'sd6400 || underrun_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL ramp_end: dout=%0d underrun=%0d, required 6400/1", dout, underrun_cnt);
        end
    endtask

    // Continue starved to five underruns, then resume the ramp from the held value.
    task automatic test_underrun();
        while (cyc < 449) begin
            tick();
            checks++;
            if (dout !== 16'sd6400) begin
                errors++;
                $display("[TB] FAIL starved_hold cyc %0d: dout=%0d, required 6400", cyc, dout);
            end
        end
        checks++;
        if (underrun_cnt !== 16'd5) begin
            errors++;
            $display("[TB] FAIL underrun_5: underrun=%0d, required 5", underrun_cnt);
        end
        send(16'sd1600, 450, "1600");
        run_to(513);
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (int'(dout) !== 6400 - 75 * k) begin
                errors++;
                $display("[TB] FAIL resume_ramp k=%0d: dout=%0d, required %0d", k, dout, 6400 - 75 * k);
            end
            tick();
        end
        checks++;
        if (dout !== 16'sd1600 || underrun_cnt !== 16'd6) begin
            errors++;
            $display("[TB] FAIL resume_end: dout=%0d underrun=%0d, required 1600/6", dout, underrun_cnt);
        end
    endtask

    // Full-scale ramp: -32768 -> 32767 must rise strictly with no wrap.
    task automatic test_full_scale();
        int prev;
        int expv;
        do_reset();
        send(-16'sd32768, 1, "min");
        send(16'sd32767, 64, "max");
        run_to(129);
        prev = -40000;
        for (int k = 0; k < 64; k++) begin
            expv = -32768 + (65535 * k) / 64;
            checks++;
            if (int'(dout) !== expv || int'(dout) <= prev) begin
                errors++;
                $display("[TB] FAIL full_scale k=%0d: dout=%0d prev=%0d, required %0d", k, dout, prev, expv);
            end
            prev = int'(dout);
            tick();
        end
        checks++;
        if (dout !== 16'sd32767) begin
            errors++;
            $display("[TB] FAIL full_scale_end: dout=%0d, required 32767", dout);
        end
    endtask

    // s_valid held high across four samples: one acceptance per segment, delivered in order.
    task automatic test_back_to_back();
        logic signed [15:0] samples [4];
        int                 acc_cyc [4];
        int                 idx;
        bit                 rdy;
        bit                 vld;
        samples[0] = 16'sd1000;
        samples[1] = -16'sd2000;
        samples[2] = 16'sd3000;
        samples[3] = -16'sd4000;
        do_reset();
        idx     = 0;
        s_valid = 1'b1;
        s_data  = samples[0];
        while (cyc < 330) begin
            rdy = s_ready;
            vld = s_valid;
            tick();
            if (vld && rdy) begin
                if (idx < 4) acc_cyc[idx] = cyc;
                idx++;
                if (idx < 4) s_data = samples[idx];
                else s_valid = 1'b0;
            end
            if (cyc <= 255) begin
                checks++;
                if (s_ready !== ((cyc % 64) == 63)) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready cyc %0d: s_ready=%0b, required %0b", cyc, s_ready, (cyc % 64) == 63);
                end
            end
            if (cyc == 129 || cyc == 193 || cyc == 257 || cyc == 321) begin
                checks++;
                if (dout !== samples[(cyc - 129) / 64]) begin
                    errors++;
                    $display("[TB] FAIL b2b_dout cyc %0d: dout=%0d, required %0d", cyc, dout, samples[(cyc - 129) / 64]);
                end
            end
        end
        checks++;
        if (idx !== 4 || acc_cyc[0] !== 1 || acc_cyc[1] !== 64 || acc_cyc[2] !== 128 || acc_cyc[3] !== 192) begin
            errors++;
            $display("[TB] FAIL b2b_accepts: count=%0d cycles %0d %0d %0d %0d, required 4 at 1 64 128 192",
                     idx, acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3]);
        end
    endtask

    // A one-cycle reset pulse at phase 30 mid-ramp aborts everything, including the buffered sample.
    task automatic test_reset_mid_ramp();
        do_reset();
        send(16'sd0, 1, "r0");
        send(16'sd6400, 64, "r6400");
        send(16'sd5000, 128, "r5000");
        run_to(158);
        checks++;
        if (dout !== 16'sd2900) begin
            errors++;
            $display("[TB] FAIL mid_ramp_pre: dout=%0d, required 2900", dout);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dout !== 16'sd0 || running !== 1'b0 || s_ready !== 1'b1 || underrun_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_ramp_reset: dout=%0d running=%0b s_ready=%0b underrun=%0d, required 0/0/1/0",
                     dout, running, s_ready, underrun_cnt);
        end
        for (int i = 0; i < 130; i++) begin
            tick();
            checks++;
            if (dout !== 16'sd0 || running !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_idle i=%0d: dout=%0d running=%0b, required 0/0", i, dout, running);
            end
        end
    endtask

    // Scenarios run in order; the underrun test continues from the ramp test's state.
    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        test_reset();
        test_ramp();
        test_underrun();
        test_full_scale();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dac_interp

// File: doc/dac_interp.md
DAC_INTERP -- requirements
Module: dac_interp

Interface
REQ-001 SHALL have parameter DATA_BW, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter OSR, default 6: log2 of the interpolation ratio N = 2**OSR clocks per input sample; it matches the downstream sigma-delta modulator's OSR.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_data  input  DATA_BW  signed input sample.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_ready  output  1  block can accept; a transfer occurs when s_valid and s_ready are both high on a clock edge.
REQ-008 SHALL have port dout  output  DATA_BW  signed interpolated sample, registered, one value per clock, feeding the modulator's din.
REQ-009 SHALL have port running  output  1  high once the first sample has been loaded.
REQ-010 SHALL have port underrun_cnt  output  16  saturating count of starved segments.

Function
REQ-011 SHALL run a phase counter 0..N-1 that increments every clock and wraps; the load event is the cycle where phase == N-1.
REQ-012 SHALL hold a one-entry buffer; s_ready = !hold_full | load_evt.
REQ-013 SHALL fill the buffer on a transfer; a transfer and a drain in the same cycle leaves the buffer full with the new sample.
REQ-014 SHALL, on a load event with the buffer full: set step <= hold - cur (DATA_BW+1 bits, signed); set acc <= cur<<OSR; set cur <= hold; drain the buffer.
REQ-015 SHALL, on a load event with the buffer empty: set step <= 0 and acc <= cur<<OSR, so dout holds cur.
REQ-016 SHALL otherwise set acc <= acc + step each clock; acc is DATA_BW+OSR+1 bits, signed.
REQ-017 SHALL register dout <= acc >>> OSR (arithmetic shift, floor); the ramp never exceeds the range of the two endpoints, so there is no saturation logic.
REQ-018 SHALL implement state machine states IDLE and RUN: IDLE->RUN on the first load event with the buffer full; RUN is left only by reset; running = (state == RUN).
REQ-019 SHALL, in IDLE, keep acc, step and cur at 0 so that dout = 0.
REQ-020 SHALL increment underrun_cnt on a load event with the buffer empty only in RUN, saturating at 65535.
REQ-021 SHALL have the following latency: with a sample loaded at the load event of cycle t, dout ramps from the previous cur at cycle t+2 and reaches the new value at cycle t+N+2.
REQ-022 SHALL ignore s_data whenever s_valid is low; no sample is lost or duplicated under any s_valid pattern.

Reset
REQ-023 SHALL, while rst is high at a clock edge, clear phase, acc, step, cur, dout, hold_full and underrun_cnt to 0, set state to IDLE, and drive running = 0 and s_ready = 1 in the following cycle.
REQ-024 SHALL treat reset during a ramp as fully abortive: any buffered sample is discarded, and dout = 0 from the cycle after rst.

Structure
REQ-025 SHALL place the state enum (IDLE, RUN) and the underrun counter width constant (16) in the shared DAC package.
REQ-026 SHALL remain a single module; a natural sub-module is dac_interp_ramp, containing the acc/step datapath.
REQ-027 SHALL be instantiated directly upstream of the sigma-delta modulator with dout wired to that modulator's din, with the same clk and matching OSR.

Verification (DATA_BW=16, OSR=6, N=64)
REQ-028 SHALL cover: reset, s_valid low for 500 cycles -> dout = 0, s_ready = 1, running = 0, underrun_cnt = 0 throughout.
REQ-029 SHALL cover: samples 0 then 6400 -> dout steps 0,100,200,...,6400, one step per clock, then holds 6400 while starved.
REQ-030 SHALL cover: samples -32768 then 32767 -> step = 65535, dout strictly monotonic from -32768 to 32767 with no wrap.
REQ-031 SHALL cover: after running = 1, s_valid low for 5 segments -> underrun_cnt = 5, dout constant; on the next sample the ramp resumes from the held value.
REQ-032 SHALL cover: s_valid held high with 4 distinct samples -> s_ready low while the buffer is full, exactly one acceptance per 64 cycles, and all 4 appear in order at dout.
REQ-033 SHALL cover: rst pulse for 1 cycle at phase 30 mid-ramp -> dout = 0, running = 0, buffer empty and underrun_cnt = 0 on the next cycle.
